// File: rtl/mem_initiator_if.sv
// CPU-side request/response and byte-wide memory bus bundle for mem_initiator.
// master = the initiator's view, slave = the core/memory side.
interface mem_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        memory_read_en;
  logic        memory_write_en;
  logic        mem_ready;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_rdata, mem_ready,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata, memory_read_en, memory_write_en
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_rdata, mem_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wdata, memory_read_en, memory_write_en
  );
endinterface

// File: rtl/mem_initiator.sv
// Splits byte/half/word loads and stores into single-byte memory accesses,
// with a one-entry last-read cache to avoid the memory's repeated-read stall.
module mem_initiator #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_initiator_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DONE} state_e;

  state_e           state_q;
  logic             req_ready_q;
  logic             resp_valid_q;
  logic             resp_err_q;
  logic [31:0]      resp_rdata_q;
  logic [31:0]      mem_addr_q;
  logic [7:0]       mem_wdata_q;
  logic             rd_en_q;
  logic             wr_en_q;
  logic [1:0]       size_q;
  logic             signed_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rbuf_q;
  logic [1:0]       idx_q;
  logic [1:0]       last_q;
  logic             hit_q;
  logic [CNT_W-1:0] cnt_q;
  logic             trk_valid_q;
  logic [31:0]      trk_addr_q;
  logic [7:0]       trk_data_q;

  logic [1:0]  last_c;
  logic [1:0]  idx_nx_c;
  logic [31:0] next_addr_c;
  logic        hit0_c;
  logic        rd_done_c;
  logic        next_hit_c;
  logic [7:0]  rd_byte_c;
  logic [31:0] word_c;
  logic [31:0] ext_c;

  assign idx_nx_c    = idx_q + 2'd1;
  assign next_addr_c = mem_addr_q + 32'd1;
  assign hit0_c      = trk_valid_q && (trk_addr_q == bus.req_addr);
  assign rd_done_c   = hit_q || bus.mem_ready;
  assign rd_byte_c   = hit_q ? trk_data_q : bus.mem_rdata;
  // After this byte completes the tracker holds either its old entry (hit) or this byte.
  assign next_hit_c  = (hit_q ? trk_addr_q : mem_addr_q) == next_addr_c;

  always_comb begin
    last_c = 2'd3;
    case (bus.req_size)
      2'd0:    last_c = 2'd0;
      2'd1:    last_c = 2'd1;
      default: last_c = 2'd3;
    endcase
  end

  // Assembled load word including the byte completing this cycle, then extended.
  always_comb begin
    word_c = rbuf_q;
    word_c[{idx_q, 3'b000} +: 8] = rd_byte_c;
  end

  always_comb begin
    ext_c = word_c;
    if (size_q == 2'd0) begin
      ext_c = {{24{signed_q & word_c[7]}}, word_c[7:0]};
    end else if (size_q == 2'd1) begin
      ext_c = {{16{signed_q & word_c[15]}}, word_c[15:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      idx_q        <= '0;
      last_q       <= '0;
      hit_q        <= 1'b0;
      cnt_q        <= '0;
      trk_valid_q  <= 1'b0;
      trk_addr_q   <= '0;
      trk_data_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            size_q      <= bus.req_size;
            signed_q    <= bus.req_signed;
            wdata_q     <= bus.req_wdata;
            last_q      <= last_c;
            idx_q       <= '0;
            cnt_q       <= '0;
            rbuf_q      <= '0;
            mem_addr_q  <= bus.req_addr;
            if (bus.req_size == 2'd3) begin
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (bus.req_write) begin
              state_q     <= S_WR;
              wr_en_q     <= 1'b1;
              mem_wdata_q <= bus.req_wdata[7:0];
              trk_valid_q <= 1'b0;
            end else begin
              state_q <= S_RD;
              hit_q   <= hit0_c;
              rd_en_q <= !hit0_c;
            end
          end
        end
        S_WR: begin
          if (idx_q == last_q) begin
            state_q      <= S_DONE;
            wr_en_q      <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
          end else begin
            idx_q       <= idx_nx_c;
            mem_addr_q  <= next_addr_c;
            mem_wdata_q <= wdata_q[{idx_nx_c, 3'b000} +: 8];
          end
        end
        S_RD: begin
          if (rd_done_c) begin
            if (!hit_q) begin
              trk_valid_q <= 1'b1;
              trk_addr_q  <= mem_addr_q;
              trk_data_q  <= bus.mem_rdata;
            end
            rbuf_q <= word_c;
            cnt_q  <= '0;
            if (idx_q == last_q) begin
              state_q      <= S_DONE;
              rd_en_q      <= 1'b0;
              hit_q        <= 1'b0;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= ext_c;
            end else begin
              idx_q      <= idx_nx_c;
              mem_addr_q <= next_addr_c;
              hit_q      <= next_hit_c;
              rd_en_q    <= !next_hit_c;
            end
          end else if (cnt_q == CNT_LAST) begin
            // Memory never answered: abandon the remaining bytes.
            state_q      <= S_DONE;
            rd_en_q      <= 1'b0;
            trk_valid_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready       = req_ready_q;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_err        = resp_err_q;
  assign bus.resp_rdata      = resp_rdata_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_wdata       = mem_wdata_q;
  assign bus.memory_read_en  = rd_en_q;
  assign bus.memory_write_en = wr_en_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: a transaction-level model predicts each
// cycle's bus outputs; a byte-wide memory model answers reads one cycle late.
module tb_mem_initiator;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_initiator_if bus();
  mem_initiator #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic        rdy;
    logic        rd;
    logic        wr;
    logic        ca;
    logic [31:0] addr;
    logic [7:0]  wd;
    logic        rv;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          e0_cyc = 0;
  bit          chk_en = 0;
  bit          stall = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  int          last_lat = 0;

  logic [7:0]  mem_m   [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic        mlast_v = 1'b0;
  logic [31:0] mlast = '0;
  bit          m_trk_v = 0;
  logic [31:0] m_trk_a = '0;
  logic [7:0]  m_trk_d = '0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_checks++;
    if (act !== ex) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, ex, cyc);
    end
  endfunction

  function automatic logic [7:0] rd_mem(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return 8'h00;
  endfunction

  function automatic logic [7:0] rd_ref(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 8'h00;
  endfunction

  function automatic exp_t mk(input logic rdy, input logic rd, input logic wr, input logic ca,
                              input logic [31:0] ad, input logic [7:0] w, input logic rv,
                              input logic er, input logic [31:0] rdat);
    exp_t e;
    e.rdy = rdy; e.rd = rd; e.wr = wr; e.ca = ca; e.addr = ad; e.wd = w;
    e.rv = rv; e.err = er; e.rdata = rdat;
    return e;
  endfunction

  // Byte-wide memory: answers a read one cycle later, never twice in a row for one address.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= 8'h00;
    end else begin
      bus.mem_ready <= 1'b0;
      if (bus.memory_write_en) begin
        mem_m[bus.mem_addr] = bus.mem_wdata;
        mlast_v = 1'b0;
      end else if (bus.memory_read_en) begin
        if (!stall && !(mlast_v && mlast == bus.mem_addr)) begin
          bus.mem_ready <= 1'b1;
          bus.mem_rdata <= rd_mem(bus.mem_addr);
        end
        mlast   = bus.mem_addr;
        mlast_v = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.req_valid && bus.req_ready) e0_cyc = cyc;
  end

  // Expected per-cycle outputs for one request, starting with the cycle it is presented.
  function automatic void build_trace(input logic wr, input logic [1:0] sz, input logic sg,
                                      input logic [31:0] a, input logic [31:0] wd);
    int          n;
    logic [31:0] word;
    logic [31:0] ba;
    logic [31:0] rdat;
    logic [7:0]  b;
    logic        err;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    if (sz == 2'd3) begin
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
      return;
    end
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        ba = a + 32'(i);
        b  = 8'(wd >> (8 * i));
        exp_q.push_back(mk(0, 0, 1, 1, ba, b, 0, 0, 0));
        ref_mem[ba] = b;
        m_trk_v = 0;
      end
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
      return;
    end
    word = '0;
    err  = 1'b0;
    for (int i = 0; i < n && !err; i++) begin
      ba = a + 32'(i);
      b  = 8'h00;
      if (m_trk_v && m_trk_a == ba) begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        b = m_trk_d;
      end else if (stall) begin
        for (int k = 0; k < int'(TO); k++) exp_q.push_back(mk(0, 1, 0, 1, ba, 0, 0, 0, 0));
        m_trk_v = 0;
        err = 1'b1;
      end else begin
        exp_q.push_back(mk(0, 1, 0, 1, ba, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 1, 0, 1, ba, 0, 0, 0, 0));
        b = rd_ref(ba);
        m_trk_v = 1; m_trk_a = ba; m_trk_d = b;
      end
      word = word | (32'(b) << (8 * i));
    end
    if (err)                        rdat = '0;
    else if (sz == 2'd2 || !sg)     rdat = word;
    else if (sz == 2'd0)            rdat = 32'($signed(word[7:0]));
    else                            rdat = 32'($signed(word[15:0]));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, err, rdat));
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("req_ready", 32'(bus.req_ready), 32'(e.rdy));
      chk("read_en", 32'(bus.memory_read_en), 32'(e.rd));
      chk("write_en", 32'(bus.memory_write_en), 32'(e.wr));
      if (e.ca) chk("mem_addr", bus.mem_addr, e.addr);
      if (e.wr) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e.wd));
      chk("resp_valid", 32'(bus.resp_valid), 32'(e.rv));
      if (e.rv) begin
        chk("resp_err", 32'(bus.resp_err), 32'(e.err));
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        last_rdata = bus.resp_rdata;
        last_err   = bus.resp_err;
        last_lat   = cyc - e0_cyc + 1;
      end
    end
  end

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    int g;
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    build_trace(wr, sz, sg, a, wd);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'hA5A5_A5A5;
    bus.req_wdata = 32'h5A5A_5A5A;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_resp_err"}, 32'(bus.resp_err), 32'd0);
    chk({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    chk({tag, "_read_en"}, 32'(bus.memory_read_en), 32'd0);
    chk({tag, "_write_en"}, 32'(bus.memory_write_en), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(posedge clk); #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    chk_en = 1;

    do_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
    chk("st_word_lat", 32'(last_lat), 32'd5);
    chk("st_word_err", 32'(last_err), 32'd0);

    do_req(0, 2'd2, 0, 32'h10, 32'h0);
    chk("ld_word_data", last_rdata, 32'hDEADBEEF);
    chk("ld_word_lat", 32'(last_lat), 32'd9);

    do_req(1, 2'd0, 0, 32'h40, 32'h55);
    do_req(0, 2'd0, 1, 32'h13, 32'h0);
    chk("ld_sb_miss_data", last_rdata, 32'hFFFFFFDE);
    chk("ld_sb_miss_lat", 32'(last_lat), 32'd3);
    do_req(0, 2'd0, 1, 32'h13, 32'h0);
    chk("ld_sb_hit_data", last_rdata, 32'hFFFFFFDE);
    chk("ld_sb_hit_lat", 32'(last_lat), 32'd2);
    do_req(0, 2'd0, 0, 32'h13, 32'h0);
    chk("ld_ub_hit_data", last_rdata, 32'h000000DE);

    do_req(1, 2'd1, 0, 32'hFFFFFFFF, 32'h00001234);
    chk("wrap_mem_hi", 32'(rd_mem(32'hFFFFFFFF)), 32'h34);
    chk("wrap_mem_lo", 32'(rd_mem(32'h00000000)), 32'h12);
    do_req(0, 2'd1, 1, 32'h12, 32'h0);
    chk("ld_sh_data", last_rdata, 32'hFFFFDEAD);
    chk("ld_sh_lat", 32'(last_lat), 32'd5);
    do_req(0, 2'd1, 1, 32'hFFFFFFFF, 32'h0);
    chk("ld_wrap_half", last_rdata, 32'h00001234);

    do_req(0, 2'd0, 0, 32'h20, 32'h0);
    stall = 1;
    do_req(0, 2'd0, 0, 32'h24, 32'h0);
    chk("timeout_err", 32'(last_err), 32'd1);
    chk("timeout_rdata", last_rdata, 32'd0);
    chk("timeout_lat", 32'(last_lat), 32'(TO + 1));
    stall = 0;
    do_req(0, 2'd0, 0, 32'h20, 32'h0);
    chk("after_to_lat", 32'(last_lat), 32'd3);

    do_req(0, 2'd3, 0, 32'h30, 32'h0);
    chk("rsvd_err", 32'(last_err), 32'd1);
    chk("rsvd_lat", 32'(last_lat), 32'd1);

    // Reset in the middle of a word load.
    @(posedge clk); #1;
    chk_en = 0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2;
    bus.req_signed = 1'b0; bus.req_addr = 32'h10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    exp_q.delete();
    m_trk_v = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1;
    repeat (3) @(negedge clk);

    do_req(0, 2'd0, 0, 32'h20, 32'h0);
    chk("post_rst_lat", 32'(last_lat), 32'd3);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
